// File: rtl/trap_sequencer.sv
// trap_sequencer: machine-mode trap/mret sequencer at writeback; flush, drain, CSR commit, redirect.
module trap_sequencer #(
  parameter int MXLEN       = 64,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_valid,
  input  logic [63:0]      wb_pc,
  input  logic             wb_excep_en,
  input  logic             wb_mret,
  input  logic [MXLEN-1:0] wb_mcause,
  input  logic [MXLEN-1:0] wb_mtval,
  input  logic             mem_busy,
  input  logic [MXLEN-1:0] csr_mip,
  input  logic [MXLEN-1:0] csr_mie,
  input  logic [MXLEN-1:0] csr_mtvec,
  input  logic [MXLEN-1:0] csr_mepc,
  input  logic [MXLEN-1:0] csr_mstatus,
  input  logic [1:0]       priv,
  input  logic             redirect_ready,
  output logic             wb_kill,
  output logic             flush,
  output logic             busy,
  output logic             csr_we,
  output logic [MXLEN-1:0] mepc_wd,
  output logic [MXLEN-1:0] mcause_wd,
  output logic [MXLEN-1:0] mtval_wd,
  output logic [MXLEN-1:0] mstatus_wd,
  output logic [1:0]       priv_wd,
  output logic             redirect_valid,
  output logic [63:0]      redirect_pc
);
  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIR} state_t;
  state_t           state;
  logic [MXLEN-1:0] pend, ms, target, ev_cause, ev_tval, last_cause, last_tval;
  logic [63:0]      ev_pc;
  logic [3:0]       code, ev_code;
  logic             irq, take, ev_trap, ev_irq;
  always_comb begin
    pend   = csr_mip & csr_mie & MXLEN'(12'h888);
    irq    = |pend && (priv != 2'b11 || csr_mstatus[3]);
    code   = pend[11] ? 4'd11 : pend[3] ? 4'd3 : 4'd7;
    take   = !reset && state == IDLE && wb_valid && (irq || wb_excep_en || wb_mret);
    ms     = csr_mstatus;
    ms[7]  = ev_trap ? csr_mstatus[3] : 1'b1;
    ms[3]  = ev_trap ? 1'b0 : csr_mstatus[7];
    ms[12:11] = ev_trap ? priv : 2'b00;
    target = ev_trap ? {csr_mtvec[MXLEN-1:2], 2'b00} +
                       ((ev_irq && VECTORED_EN && csr_mtvec[1:0] == 2'b01) ? MXLEN'({ev_code, 2'b00}) : '0)
                     : csr_mepc;
  end
  assign wb_kill    = take;
  assign flush      = take || state == DRAIN || state == COMMIT;
  assign mepc_wd    = csr_we ? (ev_trap ? ev_pc : csr_mepc) : '0;
  assign mcause_wd  = csr_we ? (ev_trap ? ev_cause : last_cause) : '0;
  assign mtval_wd   = csr_we ? (ev_trap ? ev_tval : last_tval) : '0;
  assign mstatus_wd = csr_we ? ms : '0;
  assign priv_wd    = csr_we ? (ev_trap ? 2'b11 : csr_mstatus[12:11]) : 2'b00;
  // mcause/mtval have no read port here, so the last committed values are kept for mret rewrites
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      csr_we         <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      ev_trap        <= 1'b0;
      ev_irq         <= 1'b0;
      ev_code        <= '0;
      ev_pc          <= '0;
      ev_cause       <= '0;
      ev_tval        <= '0;
      last_cause     <= '0;
      last_tval      <= '0;
    end else begin
      case (state)
        IDLE: if (take) begin
          ev_trap  <= irq || wb_excep_en;
          ev_irq   <= irq;
          ev_code  <= code;
          ev_pc    <= wb_pc;
          ev_cause <= irq ? {1'b1, {(MXLEN-5){1'b0}}, code} : wb_mcause;
          ev_tval  <= irq ? '0 : wb_mtval;
          busy     <= 1'b1;
          csr_we   <= !mem_busy;
          state    <= mem_busy ? DRAIN : COMMIT;
        end
        DRAIN: if (!mem_busy) begin
          csr_we <= 1'b1;
          state  <= COMMIT;
        end
        COMMIT: begin
          csr_we         <= 1'b0;
          redirect_valid <= 1'b1;
          redirect_pc    <= target;
          state          <= REDIR;
          if (ev_trap) begin
            last_cause <= ev_cause;
            last_tval  <= ev_tval;
          end
        end
        default: if (redirect_ready) begin
          redirect_valid <= 1'b0;
          busy           <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed checks of trap/mret sequencing with hand-computed expectations.
module tb_trap_sequencer;
  logic        clk = 1'b0, reset;
  logic        wb_valid, wb_excep_en, wb_mret, mem_busy, redirect_ready;
  logic [63:0] wb_pc, wb_mcause, wb_mtval, csr_mip, csr_mie, csr_mtvec, csr_mepc, csr_mstatus;
  logic [1:0]  priv, priv_wd;
  logic        wb_kill, flush, busy, csr_we, redirect_valid;
  logic [63:0] mepc_wd, mcause_wd, mtval_wd, mstatus_wd, redirect_pc;
  int          total = 0, bad = 0;
  trap_sequencer dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_excep_en(wb_excep_en),
    .wb_mret(wb_mret), .wb_mcause(wb_mcause), .wb_mtval(wb_mtval), .mem_busy(mem_busy),
    .csr_mip(csr_mip), .csr_mie(csr_mie), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .csr_mstatus(csr_mstatus), .priv(priv), .redirect_ready(redirect_ready), .wb_kill(wb_kill),
    .flush(flush), .busy(busy), .csr_we(csr_we), .mepc_wd(mepc_wd), .mcause_wd(mcause_wd),
    .mtval_wd(mtval_wd), .mstatus_wd(mstatus_wd), .priv_wd(priv_wd),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_we"}, csr_we, 0);
    chk({tag, "_rv"}, redirect_valid, 0);
    chk({tag, "_rpc"}, redirect_pc, 0);
    chk({tag, "_flush"}, flush, 0);
    chk({tag, "_kill"}, wb_kill, 0);
    chk({tag, "_mst"}, mstatus_wd, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
  initial begin
    reset = 1; wb_valid = 0; wb_excep_en = 0; wb_mret = 0; mem_busy = 0; redirect_ready = 1;
    wb_pc = 0; wb_mcause = 0; wb_mtval = 0; csr_mip = 0; csr_mie = 0; csr_mepc = 0;
    csr_mtvec = 64'h8000_0100; csr_mstatus = 64'h8; priv = 2'b11;
    @(negedge clk);
    chk_zero("rst");
    step; reset = 0;
    // ecall in M mode
    wb_valid = 1; wb_excep_en = 1; wb_mcause = 11; wb_pc = 64'h8000_0010;
    @(negedge clk);
    chk("ecall_kill", wb_kill, 1);
    chk("ecall_flush", flush, 1);
    chk("ecall_we_t", csr_we, 0);
    step; wb_valid = 0; wb_excep_en = 0;
    @(negedge clk);
    chk("ecall_we", csr_we, 1);
    chk("ecall_mepc", mepc_wd, 64'h8000_0010);
    chk("ecall_mcause", mcause_wd, 11);
    chk("ecall_mtval", mtval_wd, 0);
    chk("ecall_mst", mstatus_wd, 64'h1880);
    chk("ecall_priv", priv_wd, 2'b11);
    chk("ecall_rv_t1", redirect_valid, 0);
    step; @(negedge clk);
    chk("ecall_rv", redirect_valid, 1);
    chk("ecall_rpc", redirect_pc, 64'h8000_0100);
    chk("ecall_we_t2", csr_we, 0);
    step; @(negedge clk);
    chk("ecall_idle", busy, 0);
    chk("ecall_rv_off", redirect_valid, 0);
    // vectored MTI
    step; csr_mtvec = 64'h8000_0101; csr_mip = 64'h80; csr_mie = 64'h80;
    wb_valid = 1; wb_pc = 64'h8000_0040;
    @(negedge clk);
    chk("mti_kill", wb_kill, 1);
    step; wb_valid = 0;
    @(negedge clk);
    chk("mti_mcause", mcause_wd, 64'h8000_0000_0000_0007);
    chk("mti_mtval", mtval_wd, 0);
    chk("mti_mepc", mepc_wd, 64'h8000_0040);
    step; @(negedge clk);
    chk("mti_rpc", redirect_pc, 64'h8000_011C);
    step;
    // MEI + MTI + exception together
    step; csr_mip = 64'h880; csr_mie = 64'h880; wb_valid = 1; wb_excep_en = 1;
    wb_mcause = 2; wb_mtval = 64'hdead; wb_pc = 64'h8000_0080;
    @(negedge clk);
    chk("mei_kill", wb_kill, 1);
    step; wb_valid = 0; wb_excep_en = 0;
    @(negedge clk);
    chk("mei_mcause", mcause_wd, 64'h8000_0000_0000_000B);
    chk("mei_mtval", mtval_wd, 0);
    chk("mei_mepc", mepc_wd, 64'h8000_0080);
    step; @(negedge clk);
    chk("mei_rpc", redirect_pc, 64'h8000_012C);
    step;
    // drain: mem_busy high three cycles
    step; csr_mip = 0; csr_mie = 0; csr_mtvec = 64'h8000_0100;
    wb_valid = 1; wb_excep_en = 1; wb_mcause = 5; wb_mtval = 64'h77; wb_pc = 64'h8000_0300; mem_busy = 1;
    @(negedge clk);
    chk("drn_kill", wb_kill, 1);
    chk("drn_flush0", flush, 1);
    step; wb_valid = 0; wb_excep_en = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("drn_flush", flush, 1);
      chk("drn_we", csr_we, 0);
      chk("drn_busy", busy, 1);
      step;
    end
    mem_busy = 0;
    @(negedge clk);
    chk("drn_flush_end", flush, 1);
    chk("drn_we_end", csr_we, 0);
    step; @(negedge clk);
    chk("drn_we_on", csr_we, 1);
    chk("drn_mcause", mcause_wd, 5);
    chk("drn_mtval", mtval_wd, 64'h77);
    step; @(negedge clk);
    chk("drn_we_once", csr_we, 0);
    chk("drn_rv", redirect_valid, 1);
    step; @(negedge clk);
    chk("drn_idle", busy, 0);
    // mret with back-pressured redirect
    step; csr_mstatus = 64'h80; csr_mepc = 64'h8000_0200; redirect_ready = 0;
    wb_valid = 1; wb_mret = 1; wb_pc = 64'h8000_0400;
    @(negedge clk);
    chk("mret_kill", wb_kill, 1);
    step; wb_valid = 0; wb_mret = 0;
    @(negedge clk);
    chk("mret_we", csr_we, 1);
    chk("mret_priv", priv_wd, 2'b00);
    chk("mret_mst", mstatus_wd, 64'h88);
    chk("mret_mepc", mepc_wd, 64'h8000_0200);
    chk("mret_mcause", mcause_wd, 5);
    chk("mret_mtval", mtval_wd, 64'h77);
    step; csr_mepc = 64'h1111; wb_valid = 1; wb_excep_en = 1;
    @(negedge clk);
    chk("mret_rv", redirect_valid, 1);
    chk("mret_rpc", redirect_pc, 64'h8000_0200);
    chk("mret_nokill", wb_kill, 0);
    for (int i = 0; i < 4; i++) begin
      step; @(negedge clk);
      chk("mret_hold_rv", redirect_valid, 1);
      chk("mret_hold_rpc", redirect_pc, 64'h8000_0200);
    end
    step; wb_valid = 0; wb_excep_en = 0; redirect_ready = 1;
    @(negedge clk);
    chk("mret_hs_rv", redirect_valid, 1);
    step; @(negedge clk);
    chk("mret_rv_off", redirect_valid, 0);
    chk("mret_idle", busy, 0);
    // reset in the middle of REDIRECT
    step; csr_mstatus = 64'h8; csr_mepc = 0; redirect_ready = 0;
    wb_valid = 1; wb_excep_en = 1; wb_mcause = 11; wb_mtval = 0; wb_pc = 64'h8000_0500;
    step; wb_valid = 0; wb_excep_en = 0;
    step; @(negedge clk);
    chk("rr_rv", redirect_valid, 1);
    reset = 1;
    #1;
    chk_zero("rr");
    step; reset = 0; redirect_ready = 1;
    step; wb_valid = 1; wb_excep_en = 1; wb_pc = 64'h8000_0600;
    @(negedge clk);
    chk("post_kill", wb_kill, 1);
    step; wb_valid = 0; wb_excep_en = 0;
    @(negedge clk);
    chk("post_we", csr_we, 1);
    chk("post_mepc", mepc_wd, 64'h8000_0600);
    step; @(negedge clk);
    chk("post_rpc", redirect_pc, 64'h8000_0100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
